dmem_bridge: RTL and testbench

- Data-memory bridge between the single-cycle CPU data port (data_read/data_write/data_addr/data_in/data_out) and a multi-cycle SRAM/bus with a request/grant/rvalid handshake.
- Holds a one-entry posted write buffer and forwards read-after-write hits from it.
- Raises stall so the CPU holds its PC and data-port signals while a memory access is outstanding.
- Detects a read-response timeout and substitutes a fixed error word.

---
 rtl/dmem_bridge_if.sv | 20 ++
 rtl/dmem_bridge.sv | 152 +++++++++++++++
 tb/tb_dmem_bridge.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_bridge_if.sv
// Request/grant/rvalid bus between the data-memory bridge (master) and the SRAM side (slave).
interface dmem_bridge_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/dmem_bridge.sv
// Data-memory bridge: single-cycle CPU data port onto a request/grant/rvalid bus, with a
// one-entry posted write buffer, read-after-write forwarding and a read-response timeout.
module dmem_bridge #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_WORD = 32'hDEADBEEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          data_read,
    input  logic          data_write,
    input  logic [31:0]   data_addr,
    input  logic [31:0]   data_in,
    output logic [31:0]   data_out,
    output logic          stall,
    output logic          bus_err,
    dmem_bridge_if.master bus
);
    localparam int unsigned    CntW   = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StRdReq, StRdWait, StRdDone} state_e;

    state_e          state_q, state_d;
    logic            wv_q, wv_d;
    logic [29:0]     wbuf_addr_q, wbuf_addr_d;
    logic [31:0]     wbuf_data_q, wbuf_data_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [31:0]     out_q, out_d;
    logic            err_q, err_d;
    logic            is_rd, hit;
    logic            unused_addr_bits;

    assign unused_addr_bits = ^data_addr[1:0];

    // A simultaneous read and write is treated as a write.
    assign is_rd    = data_read & ~data_write;
    assign hit      = is_rd & wv_q & (data_addr[31:2] == wbuf_addr_q);
    assign data_out = hit ? wbuf_data_q : out_q;
    assign bus_err  = err_q;

    always_comb begin
        state_d       = state_q;
        wv_d          = wv_q;
        wbuf_addr_d   = wbuf_addr_q;
        wbuf_data_d   = wbuf_data_q;
        cnt_d         = cnt_q;
        out_d         = out_q;
        err_d         = err_q;
        cnt_inc       = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
        stall         = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;

        // The buffered write owns the bus whenever it is valid.
        if (wv_q) begin
            bus.mem_req   = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_addr  = {wbuf_addr_q, 2'b00};
            bus.mem_wdata = wbuf_data_q;
            if (bus.mem_gnt) begin
                wv_d = 1'b0;
            end
        end

        case (state_q)
            StIdle: begin
                if (data_write) begin
                    stall = wv_q & ~bus.mem_gnt;
                end else if (is_rd && !hit) begin
                    stall = 1'b1;
                    if (!wv_q) begin
                        // Empty buffer: issue the read straight away to save a cycle.
                        bus.mem_req  = 1'b1;
                        bus.mem_addr = {data_addr[31:2], 2'b00};
                        cnt_d        = '0;
                        state_d      = bus.mem_gnt ? StRdWait : StRdReq;
                    end else if (bus.mem_gnt) begin
                        state_d = StRdReq;
                    end
                end
            end
            StRdReq: begin
                stall        = 1'b1;
                bus.mem_req  = 1'b1;
                bus.mem_addr = {data_addr[31:2], 2'b00};
                if (bus.mem_gnt) begin
                    cnt_d   = '0;
                    state_d = StRdWait;
                end
            end
            StRdWait: begin
                stall = 1'b1;
                cnt_d = cnt_inc;
                if (bus.mem_rvalid) begin
                    out_d   = bus.mem_rdata;
                    state_d = StRdDone;
                end else if (cnt_inc == CntMax) begin
                    out_d   = ERR_WORD;
                    err_d   = 1'b1;
                    state_d = StRdDone;
                end
            end
            StRdDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (data_write && !stall) begin
            wv_d        = 1'b1;
            wbuf_addr_d = data_addr[31:2];
            wbuf_data_d = data_in;
        end

        // A forwarded load becomes the value data_out holds afterwards.
        if (hit) begin
            out_d = wbuf_data_q;
        end

        if (!rst) begin
            stall         = 1'b0;
            bus.mem_req   = 1'b0;
            bus.mem_we    = 1'b0;
            bus.mem_addr  = '0;
            bus.mem_wdata = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            wv_q        <= 1'b0;
            wbuf_addr_q <= '0;
            wbuf_data_q <= '0;
            cnt_q       <= '0;
            out_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wv_q        <= wv_d;
            wbuf_addr_q <= wbuf_addr_d;
            wbuf_data_q <= wbuf_data_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            err_q       <= err_d;
        end
    end
endmodule

// File: tb/tb_dmem_bridge.sv
// Bench for dmem_bridge: directed cases with literal expectations, then randomized load/store
// traffic checked every cycle against a word-level memory model and a pending-store queue.
module tb_dmem_bridge;
    localparam int unsigned TO  = 4;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        data_read = 1'b0;
    logic        data_write = 1'b0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        stall;
    logic        bus_err;

    dmem_bridge_if bus ();

    dmem_bridge #(.TIMEOUT(TO), .ERR_WORD(ERR)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_read  (data_read),
        .data_write (data_write),
        .data_addr  (data_addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .stall      (stall),
        .bus_err    (bus_err),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory image seen by the CPU (program order) and the SRAM contents (bus order).
    logic [31:0] ref_mem [logic [29:0]];
    logic [31:0] sram    [logic [29:0]];

    function automatic logic [31:0] init_val(input logic [29:0] w);
        return {w, 2'b00} ^ 32'h3C3C_5A5A;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [29:0] w);
        return ref_mem.exists(w) ? ref_mem[w] : init_val(w);
    endfunction

    function automatic logic [31:0] sram_rd(input logic [29:0] w);
        return sram.exists(w) ? sram[w] : init_val(w);
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        ref_mem[a[31:2]] = d;
        sram[a[31:2]]    = d;
    endtask

    // Slave behaviour knobs: 0 random grant, 1 grant high, 2 grant low.
    int gnt_mode    = 1;
    int fixed_delay = 1;
    bit no_rv       = 1'b0;
    bit spur_en     = 1'b0;

    initial begin : slave
        logic        hs, hs_we;
        logic [29:0] hs_w, rd_w;
        logic [31:0] hs_d;
        int          rd_left;
        bit          rd_pend;
        hs = 1'b0; hs_we = 1'b0; hs_w = '0; rd_w = '0; hs_d = '0;
        rd_left = 0; rd_pend = 1'b0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst) rd_pend = 1'b0;
            hs    = bus.mem_req && bus.mem_gnt && rst;
            hs_we = bus.mem_we;
            hs_w  = bus.mem_addr[31:2];
            hs_d  = bus.mem_wdata;
            @(posedge clk);
            #2;
            if (!rst) begin
                hs = 1'b0;
                rd_pend = 1'b0;
            end
            if (hs && hs_we) begin
                sram[hs_w] = hs_d;
            end else if (hs) begin
                rd_pend = 1'b1;
                rd_w    = hs_w;
                rd_left = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 3));
            end
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = $urandom;
            if (rd_pend && !no_rv) begin
                rd_left--;
                if (rd_left == 0) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = sram_rd(rd_w);
                    rd_pend        = 1'b0;
                end
            end else if (!rd_pend && spur_en && $urandom_range(0, 9) == 0) begin
                bus.mem_rvalid = 1'b1;
            end
            bus.mem_gnt = (gnt_mode == 0) ? 1'($urandom_range(0, 1)) : 1'(gnt_mode == 1);
        end
    end

    typedef struct packed {
        logic [29:0] w;
        logic [31:0] d;
    } wr_t;

    wr_t         store_q[$];
    logic [31:0] last_ret;
    bit          exp_err;

    initial begin : compare
        bit          ld, st, wgnt, fwd;
        logic [29:0] aw;
        logic [31:0] exp;
        last_ret = '0;
        exp_err  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                store_q.delete();
                last_ret = '0;
                exp_err  = 1'b0;
            end else begin
                ld   = data_read && !data_write;
                st   = data_write;
                aw   = data_addr[31:2];
                wgnt = bus.mem_req && bus.mem_we && bus.mem_gnt;
                fwd  = ld && store_q.size() != 0 && store_q[$].w == aw;
                if (store_q.size() != 0)
                    check("drain_req", 32'({bus.mem_req, bus.mem_we}), 32'd3);
                if (st) begin
                    if (store_q.size() == 0) check("store_empty_stall", 32'(stall), 32'd0);
                    else check("store_full_stall", 32'(stall), 32'(!wgnt));
                end
                if (ld && store_q.size() != 0) begin
                    if (fwd) check("fwd_stall", 32'(stall), 32'd0);
                    else check("raw_order_stall", 32'(stall), 32'd1);
                end
                if (ld && !stall) begin
                    exp = (no_rv && !fwd) ? ERR : ref_rd(aw);
                    if (no_rv && !fwd) exp_err = 1'b1;
                    check("load_data", data_out, exp);
                    last_ret = exp;
                end else begin
                    check("data_out_hold", data_out, last_ret);
                end
                check("bus_err", 32'(bus_err), 32'(exp_err));
                if (bus.mem_req) check("addr_align", 32'(bus.mem_addr[1:0]), 32'd0);
                if (bus.mem_req && !bus.mem_we) begin
                    check("rd_req_addr", bus.mem_addr, {aw, 2'b00});
                    check("rd_req_order", 32'(store_q.size() == 0 && ld), 32'd1);
                end
                if (wgnt) begin
                    if (store_q.size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL bus_write: got write to %h want none", bus.mem_addr);
                    end else begin
                        check("wr_addr", bus.mem_addr, {store_q[0].w, 2'b00});
                        check("wr_data", bus.mem_wdata, store_q[0].d);
                        void'(store_q.pop_front());
                    end
                end
                if (st && !stall) begin
                    store_q.push_back('{w: aw, d: data_in});
                    ref_mem[aw] = data_in;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for the current CPU access to complete; returns at that negedge.
    task automatic wait_done(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!stall) return;
        end
        n_chk++;
        n_err++;
        $display("FAIL %s: stall still 1 after 40 cycles, want 0", name);
    endtask

    task automatic op(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        data_read  = rd;
        data_write = wr;
        data_addr  = a;
        data_in    = d;
        if (rd || wr) wait_done("op_done");
        else @(negedge clk);
        tick();
        data_read  = 1'b0;
        data_write = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_req", 32'(bus.mem_req), 32'd0);
        check("rst_we", 32'(bus.mem_we), 32'd0);
        check("rst_addr", bus.mem_addr, 32'd0);
        check("rst_wdata", bus.mem_wdata, 32'd0);
        check("rst_data_out", data_out, 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        rst = 1'b1;
        tick();

        // Posted store with grant tied high.
        data_write = 1'b1; data_addr = 32'h100; data_in = 32'h1234_5678;
        @(negedge clk); check("post_stall", 32'(stall), 32'd0);
        tick(); data_write = 1'b0;
        @(negedge clk);
        check("post_req", 32'({bus.mem_req, bus.mem_we}), 32'd3);
        check("post_addr", bus.mem_addr, 32'h100);
        check("post_wdata", bus.mem_wdata, 32'h1234_5678);
        tick();
        @(negedge clk); check("post_one_cycle", 32'(bus.mem_req), 32'd0);
        tick();

        // Forwarding from the buffer while the drain is held off.
        gnt_mode = 2;
        data_write = 1'b1; data_addr = 32'h200; data_in = 32'hA5A5_A5A5;
        tick();
        data_write = 1'b0; data_read = 1'b1; data_addr = 32'h202;
        @(negedge clk);
        check("fwd_stall_lit", 32'(stall), 32'd0);
        check("fwd_data_lit", data_out, 32'hA5A5_A5A5);
        check("fwd_no_read", 32'(bus.mem_req && !bus.mem_we), 32'd0);
        tick(); data_read = 1'b0; gnt_mode = 1;
        tick(); tick();

        // Read miss: two stall cycles, data in the third.
        preload(32'h300, 32'hCAFE_F00D);
        data_read = 1'b1; data_addr = 32'h300;
        @(negedge clk); check("miss_stall0", 32'(stall), 32'd1);
        tick();
        @(negedge clk); check("miss_stall1", 32'(stall), 32'd1);
        tick();
        @(negedge clk);
        check("miss_stall2", 32'(stall), 32'd0);
        check("miss_data", data_out, 32'hCAFE_F00D);
        tick(); data_read = 1'b0; tick();

        // Ordering: buffered write must reach the bus before the read.
        preload(32'h500, 32'h5005_0050);
        gnt_mode = 2;
        data_write = 1'b1; data_addr = 32'h400; data_in = 32'h4444_0000;
        @(negedge clk); check("ord_wr_stall", 32'(stall), 32'd0);
        tick();
        data_write = 1'b0; data_read = 1'b1; data_addr = 32'h500;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ord_hold_stall", 32'(stall), 32'd1);
            check("ord_hold_addr", bus.mem_addr, 32'h400);
            tick();
        end
        gnt_mode = 1;
        @(negedge clk);
        check("ord_gnt_stall", 32'(stall), 32'd1);
        check("ord_gnt_we", 32'(bus.mem_we), 32'd1);
        tick();
        @(negedge clk);
        check("ord_rd_stall", 32'(stall), 32'd1);
        check("ord_rd_req", 32'({bus.mem_req, bus.mem_we}), 32'd2);
        check("ord_rd_addr", bus.mem_addr, 32'h500);
        tick();
        @(negedge clk); check("ord_wait_stall", 32'(stall), 32'd1);
        tick();
        @(negedge clk);
        check("ord_done_stall", 32'(stall), 32'd0);
        check("ord_done_data", data_out, 32'h5005_0050);
        tick(); data_read = 1'b0; tick();

        // Timeout: rvalid never comes.
        no_rv = 1'b1;
        data_read = 1'b1; data_addr = 32'h600;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); check("to_stall", 32'(stall), 32'd1);
            tick();
        end
        @(negedge clk);
        check("to_done_stall", 32'(stall), 32'd0);
        check("to_data", data_out, ERR);
        check("to_err", 32'(bus_err), 32'd1);
        tick(); data_read = 1'b0;
        repeat (3) tick();
        @(negedge clk); check("to_err_sticky", 32'(bus_err), 32'd1);
        tick();

        // Reset while waiting for read data.
        preload(32'h700, 32'h7777_0700);
        data_read = 1'b1; data_addr = 32'h700;
        @(negedge clk);
        tick();
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_req", 32'(bus.mem_req), 32'd0);
        check("mid_rst_stall", 32'(stall), 32'd0);
        check("mid_rst_err", 32'(bus_err), 32'd0);
        check("mid_rst_data", data_out, 32'd0);
        no_rv = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        wait_done("rst_reload_done");
        check("rst_reload_data", data_out, 32'h7777_0700);
        tick(); data_read = 1'b0; tick();

        // Randomized traffic over a few words so forwarding and ordering cases recur.
        gnt_mode = 0; spur_en = 1'b1; fixed_delay = 0;
        for (int n = 0; n < 300; n++) begin
            int          k;
            logic [31:0] a;
            k = int'($urandom_range(0, 19));
            a = 32'h1000 + 32'($urandom_range(0, 3)) * 32'd4 + 32'($urandom_range(0, 3));
            if (k < 8) op(1'b0, 1'b1, a, $urandom);
            else if (k < 17) op(1'b1, 1'b0, a, 32'd0);
            else if (k < 19) op(1'b1, 1'b1, a, $urandom);
            else op(1'b0, 1'b0, a, 32'd0);
        end
        gnt_mode = 1;
        repeat (3) tick();
        check("final_drained", 32'(store_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
